// File: rtl/ibuf_sched_pkg.sv
// Shared parameters, state encoding and helpers for the input-buffer scheduler
// and the systolic array top that consumes its strobes.
package ibuf_sched_pkg;

    localparam int NCOL      = 4;
    localparam int DEPTH     = 4;
    localparam int SHIFT_LEN = NCOL + DEPTH - 1;
    localparam int COL_W     = $clog2(NCOL);
    localparam int T_W       = $clog2(SHIFT_LEN);
    localparam int WORD_W    = 8 * DEPTH;
    localparam int TILE_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic [NCOL-1:0] col_onehot(input logic [COL_W-1:0] col);
        logic [NCOL-1:0] oh;
        oh      = '0;
        oh[col] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/ibuf_sched_chk.sv
// Protocol checker: a column is never loaded and shifted in the same cycle,
// and Done is a single-cycle pulse.
module ibuf_sched_chk
    import ibuf_sched_pkg::*;
(
    input logic            CLK,
    input logic            RST,
    input logic [NCOL-1:0] WriteEN,
    input logic [NCOL-1:0] ShiftEN,
    input logic            Done
);

    a_no_load_shift_overlap: assert property (
        @(posedge CLK) disable iff (RST) ((WriteEN & ShiftEN) == '0)
    );

    a_done_single_pulse: assert property (
        @(posedge CLK) disable iff (RST) (Done |=> !Done)
    );

endmodule

// File: rtl/ibuf_sched_shift_skew_dec.sv
// Skewed shift-window decode: column c shifts for DEPTH cycles starting at
// window step c, so data enters the array as a diagonal wavefront.
module shift_skew_dec
    import ibuf_sched_pkg::*;
(
    input  logic [T_W-1:0]  t_i,
    output logic [NCOL-1:0] shift_en_o
);

    // Per-column window membership test
    always_comb begin
        shift_en_o = '0;
        for (int c = 0; c < NCOL; c++) begin
            if ((int'(t_i) >= c) && (int'(t_i) <= c + DEPTH - 1)) begin
                shift_en_o[c] = 1'b1;
            end else begin
                shift_en_o[c] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ibuf_sched.sv
// Input-buffer scheduler: loads NCOL column words per tile through a
// valid/ready handshake, then runs the skewed shift window, for NumTiles tiles.
module ibuf_sched
    import ibuf_sched_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              Start,
    input  logic [TILE_W-1:0] NumTiles,
    input  logic              IValid,
    input  logic [WORD_W-1:0] IWordIn,
    output logic              IReady,
    output logic [NCOL-1:0]   WriteEN,
    output logic [WORD_W-1:0] IWord,
    output logic [NCOL-1:0]   ShiftEN,
    output logic              Busy,
    output logic              Done
);

    state_e             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [T_W-1:0]     t_q, t_d;
    logic [TILE_W-1:0]  tiles_q, tiles_d;
    logic [TILE_W-1:0]  num_tiles_q, num_tiles_d;
    logic [NCOL-1:0]    write_en_q, write_en_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [TILE_W-1:0]  tiles_inc_s;
    logic [NCOL-1:0]    skew_s;

    assign tiles_inc_s = tiles_q + 8'd1;

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        t_d         = t_q;
        tiles_d     = tiles_q;
        num_tiles_d = num_tiles_q;
        write_en_d  = '0;
        word_d      = word_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    if (NumTiles != 8'd0) begin
                        state_d     = ST_LOAD;
                        num_tiles_d = NumTiles;
                        tiles_d     = 8'd0;
                        col_d       = '0;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (IValid) begin
                    word_d     = IWordIn;
                    write_en_d = col_onehot(col_q);
                    if (col_q == COL_W'(NCOL - 1)) begin
                        col_d   = '0;
                        t_d     = '0;
                        state_d = ST_SHIFT;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_SHIFT: begin
                if (t_q == T_W'(SHIFT_LEN - 1)) begin
                    t_d     = '0;
                    tiles_d = tiles_inc_s;
                    // Counter never exceeds NumTiles, so 255 tiles need no wider compare
                    if (tiles_inc_s < num_tiles_q) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    t_d = t_q + 3'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                tiles_d = 8'd0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            t_q         <= '0;
            tiles_q     <= 8'd0;
            num_tiles_q <= 8'd0;
            write_en_q  <= '0;
            word_q      <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            t_q         <= t_d;
            tiles_q     <= tiles_d;
            num_tiles_q <= num_tiles_d;
            write_en_q  <= write_en_d;
            word_q      <= word_d;
        end
    end

    shift_skew_dec u_skew (
        .t_i        (t_q),
        .shift_en_o (skew_s)
    );

    assign IReady  = (state_q == ST_LOAD);
    assign Busy    = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
    assign Done    = (state_q == ST_DONE);
    assign ShiftEN = (state_q == ST_SHIFT) ? skew_s : '0;
    assign WriteEN = write_en_q;
    assign IWord   = word_q;

endmodule

// File: tb/tb_ibuf_sched.sv
// Randomized self-checking bench for ibuf_sched against a job-level model.
module tb_ibuf_sched;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Start;
    logic [7:0]  NumTiles;
    logic        IValid;
    logic [31:0] IWordIn;
    logic        IReady;
    logic [3:0]  WriteEN;
    logic [31:0] IWord;
    logic [3:0]  ShiftEN;
    logic        Busy;
    logic        Done;

    always #5 CLK = ~CLK;

    ibuf_sched dut (
        .CLK(CLK), .RST(RST), .Start(Start), .NumTiles(NumTiles),
        .IValid(IValid), .IWordIn(IWordIn), .IReady(IReady), .WriteEN(WriteEN),
        .IWord(IWord), .ShiftEN(ShiftEN), .Busy(Busy), .Done(Done)
    );

    ibuf_sched_chk chk (
        .CLK(CLK), .RST(RST), .WriteEN(WriteEN), .ShiftEN(ShiftEN), .Done(Done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Job-level model: phase 0 idle, 1 collecting words, 2 shifting, 3 done
    int          m_phase = 0;
    int          m_words = 0;
    int          m_step  = 0;
    int          m_tiles = 0;
    int          m_goal  = 0;
    logic [3:0]  m_wr    = 4'b0;
    logic [31:0] m_word  = 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [3:0] window(input int t);
        logic [3:0] r;
        r = 4'b0;
        for (int c = 0; c < 4; c++) r[c] = (t >= c) && (t < c + 4);
        return r;
    endfunction

    task automatic model_step();
        logic [3:0] wr;
        wr = 4'b0;
        if (RST) begin
            m_phase = 0; m_words = 0; m_step = 0; m_tiles = 0; m_goal = 0; m_word = 32'h0;
        end else if (m_phase == 0) begin
            if (Start) begin
                m_goal  = int'(NumTiles);
                m_tiles = 0;
                m_words = 0;
                m_phase = (m_goal == 0) ? 3 : 1;
            end
        end else if (m_phase == 1) begin
            if (IValid) begin
                wr      = 4'b0001 << m_words;
                m_word  = IWordIn;
                m_words = m_words + 1;
                if (m_words == 4) begin
                    m_words = 0; m_step = 0; m_phase = 2;
                end
            end
        end else if (m_phase == 2) begin
            if (m_step == 6) begin
                m_tiles = m_tiles + 1;
                m_step  = 0;
                m_phase = (m_tiles < m_goal) ? 1 : 3;
            end else begin
                m_step = m_step + 1;
            end
        end else begin
            m_phase = 0;
        end
        m_wr = wr;
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        check("IReady", 32'(IReady), 32'(m_phase == 1));
        check("Busy", 32'(Busy), 32'(m_phase == 1 || m_phase == 2));
        check("Done", 32'(Done), 32'(m_phase == 3));
        check("WriteEN", 32'(WriteEN), 32'(m_wr));
        check("IWord", IWord, m_word);
        check("ShiftEN", 32'(ShiftEN), (m_phase == 2) ? 32'(window(m_step)) : 32'h0);
    endtask

    task automatic run_job(input int nt, input int valid_pct, input int budget);
        int cyc   = 0;
        int dones = 0;
        int wes   = 0;
        int shs   = 0;
        Start = 1'b1; NumTiles = 8'(nt); IValid = 1'b0;
        tick();
        dones += int'(Done);
        while (m_phase != 0 && cyc < budget) begin
            IValid   = 1'($urandom_range(99) < 32'(valid_pct));
            IWordIn  = $urandom;
            Start    = 1'($urandom_range(15) == 0);
            NumTiles = 8'($urandom);
            tick();
            cyc++;
            dones += int'(Done);
            wes   += int'(WriteEN != 4'b0);
            shs   += int'(ShiftEN != 4'b0);
        end
        Start = 1'b0; IValid = 1'b0;
        check("done_count", 32'(dones), 32'd1);
        check("write_count", 32'(wes), 32'(4 * nt));
        check("shift_cycles", 32'(shs), 32'(7 * nt));
    endtask

    logic [31:0] dir_words [4]  = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
    logic [3:0]  dir_we    [12] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0]  dir_se    [12] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0, 4'h0};
    logic        dir_dn    [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        stall_pat [8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        int wait_cyc;
        RST = 1'b1; Start = 1'b0; NumTiles = 8'd0; IValid = 1'b0; IWordIn = 32'h0;
        tick(); tick();
        RST = 1'b0;
        tick();

        // Single tile with known words and a fixed expected strobe table
        Start = 1'b1; NumTiles = 8'd1;
        tick();
        Start = 1'b0; IValid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            IWordIn = (i < 4) ? dir_words[i] : 32'hDEADBEEF;
            tick();
            check("dir_we", 32'(WriteEN), 32'(dir_we[i]));
            check("dir_se", 32'(ShiftEN), 32'(dir_se[i]));
            check("dir_done", 32'(Done), 32'(dir_dn[i]));
        end
        IValid = 1'b0;

        // Three-cycle stall between handshakes 1 and 2
        Start = 1'b1; NumTiles = 8'd1;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            IValid  = (i < 8) ? stall_pat[i] : 1'b1;
            IWordIn = $urandom;
            tick();
        end
        IValid = 1'b0;
        check("stall_idle", 32'(Busy), 32'd0);

        run_job(0, 100, 10);
        run_job(3, 100, 60);
        run_job(3, 60, 200);

        // Reset while shifting at window step 2
        Start = 1'b1; NumTiles = 8'd2;
        tick();
        Start = 1'b0; IValid = 1'b1;
        wait_cyc = 0;
        while (!(m_phase == 2 && m_step == 2) && wait_cyc < 40) begin
            IWordIn = $urandom;
            tick();
            wait_cyc++;
        end
        check("reach_shift_t2", 32'(ShiftEN), 32'h7);
        RST = 1'b1;
        tick();
        RST = 1'b0; IValid = 1'b0;
        check("rst_shift", 32'(ShiftEN), 32'h0);
        check("rst_busy", 32'(Busy), 32'h0);
        check("rst_iword", IWord, 32'h0);
        run_job(1, 100, 40);

        run_job(255, 100, 3000);

        for (int j = 0; j < 25; j++) begin
            run_job(int'($urandom_range(4)), int'($urandom_range(100, 40)), 400);
        end

        // Fully random inputs including occasional reset
        for (int i = 0; i < 800; i++) begin
            RST      = 1'($urandom_range(63) == 0);
            Start    = 1'($urandom_range(7) == 0);
            NumTiles = 8'($urandom_range(3));
            IValid   = 1'($urandom_range(3) != 0);
            IWordIn  = $urandom;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ibuf_sched.md
IBUF_SCHED -- requirements
Module: ibuf_sched

Interface
REQ-001 SHALL have one clock and synchronous active-high reset: all state changes on rising CLK; RST sampled only at rising CLK.
REQ-002 SHALL expose ports (name direction width meaning):
  CLK  input  1  clock
  RST  input  1  synchronous reset, active-high
  Start  input  1  single-cycle request to run a job
  NumTiles  input  8  tiles per job, sampled when Start accepted
  IValid  input  1  source word valid
  IWordIn  input  32  source word, {col-elem0..elem3} byte order MSB first
  IReady  output  1  scheduler ready to accept a word
  WriteEN  output  4  one-hot load strobe, bit c = column buffer c
  IWord  output  32  registered word broadcast to all column buffers
  ShiftEN  output  4  per-column shift enable, skewed by column index
  Busy  output  1  job in progress
  Done  output  1  single-cycle job-complete pulse
REQ-003 SHALL fix parameters: NCOL = 4 columns, DEPTH = 4 bytes per column word.

Function
REQ-004 SHALL implement FSM states IDLE, LOAD, SHIFT, DONE.
REQ-005 IDLE: Start=1 with NumTiles>0 -> LOAD next cycle; Start=1 with NumTiles=0 -> DONE next cycle; Start ignored in all other states.
REQ-006 LOAD: IReady=1; each cycle with IValid&IReady is a handshake; IReady=0 in every other state.
REQ-007 On handshake n (n=0..3) in cycle k, IWord SHALL equal IWordIn and WriteEN SHALL equal one-hot bit n in cycle k+1; WriteEN=0 in all other cycles.
REQ-008 IValid low in LOAD SHALL stall: column counter holds, WriteEN=0, no state change.
REQ-009 After handshake 3, state SHALL be SHIFT in the next cycle; IWord holds last value outside handshakes.
REQ-010 SHIFT SHALL last exactly 7 cycles, t=0..6; ShiftEN[c]=1 iff c<=t<=c+3 (each column shifts 4 consecutive cycles, column c delayed c cycles).
REQ-011 ShiftEN SHALL be decoded only from registered state (no input path to ShiftEN).
REQ-012 At t=6: tile counter increments; if tiles done < NumTiles latched -> LOAD next cycle, else DONE next cycle.
REQ-013 DONE: Done=1 for exactly one cycle, then IDLE; Busy=1 in LOAD and SHIFT only.
REQ-014 WriteEN[c] and ShiftEN[c] SHALL never be 1 in the same cycle for the same c.
REQ-015 Tile counter 8 bits, no wrap: NumTiles=255 runs 255 tiles.

Reset
REQ-016 RST=1 SHALL force IDLE, counters 0, and IReady, WriteEN, IWord, ShiftEN, Busy, Done all 0 in the following cycle, including mid-LOAD or mid-SHIFT.
REQ-017 RST SHALL take priority over Start and IValid in the same cycle.

Structure
REQ-018 NCOL, DEPTH, state encoding and shift-window length (NCOL+DEPTH-1) SHALL live in a shared package used by ibuf_sched and the array top.
REQ-019 Skew decode MAY be a sub-module shift_skew_dec (t in, ShiftEN out); no other hierarchy.

Verification
REQ-020 NumTiles=1, IValid always 1, words 0x01020304, 0x05060708, 0x090A0B0C, 0x0D0E0F10 -> WriteEN 0001,0010,0100,1000 in consecutive cycles with matching IWord; ShiftEN 0001,0011,0111,1111,1110,1100,1000; Done one cycle later.
REQ-021 IValid low 3 cycles between handshakes 1 and 2 -> WriteEN gap of 3 cycles, IReady held 1, ShiftEN pattern unchanged.
REQ-022 NumTiles=0 -> Done 1 cycle after Start, no IReady, WriteEN or ShiftEN activity.
REQ-023 NumTiles=3 -> three LOAD/SHIFT sequences back-to-back, single Done after third SHIFT t=6; Start pulsed mid-job ignored.
REQ-024 RST at SHIFT t=2 -> next cycle all outputs 0, IDLE; fresh Start then completes normally.
REQ-025 Checker asserts REQ-014 and Done width of 1 in every scenario.
